// File: rtl/counter_4bit_div_pkg.sv
// rtl/counter_4bit_div_pkg.sv - shared constants and next-count helper for counter_4bit_div
package counter_4bit_div_pkg;

  localparam int         CNT_W     = 4;
  localparam logic [3:0] SET_VALUE = 4'hF;

  // Wraps naturally at the register width; there is no terminal-count flag.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/counter_4bit_div.sv
// rtl/counter_4bit_div.sv - free-running 4-bit up-counter with async set and clk/2, clk/4 taps
module counter_4bit_div
  import counter_4bit_div_pkg::*;
(
  input  logic             clk,
  input  logic             aset,
  output logic [CNT_W-1:0] out,
  output logic             CLK_DIV_2,
  output logic             CLK_DIV_4
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge aset) begin
    if (aset) begin
      count <= SET_VALUE;
    end else begin
      count <= next_count(count);
    end
  end

  // Dividers are straight flop taps so downstream clocking sees no glitches.
  assign out       = count;
  assign CLK_DIV_2 = count[0];
  assign CLK_DIV_4 = count[1];

endmodule

// File: tb/tb_counter_4bit_div.sv
// tb/tb_counter_4bit_div.sv - self-checking bench for counter_4bit_div
module tb_counter_4bit_div;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       aset = 1'b0;
  logic [3:0] out;
  logic       div2;
  logic       div4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic aset;
    int   exp_out;
    int   exp_d2;
    int   exp_d4;
  } vec_t;

  vec_t vecs[20];

  counter_4bit_div dut (
    .clk       (clk),
    .aset      (aset),
    .out       (out),
    .CLK_DIV_2 (div2),
    .CLK_DIV_4 (div4)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int val);
    check({name, "_out"}, int'(out), val);
    check({name, "_div2"}, int'(div2), val % 2);
    check({name, "_div4"}, int'(div4), (val / 2) % 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int model;
    int prev_d2;
    int prev_d4;
    int rise_d2;
    int rise_d4;

    // Set held over 3 edges, 16 counting edges 0..F, then the wrap back to 0.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 15, 1, 1};
    for (int i = 0; i < 16; i++) vecs[3+i] = '{1'b0, i, i % 2, (i / 2) % 2};
    vecs[19] = '{1'b0, 0, 0, 0};

    #1 aset = 1'b1;
    #1 check_all("async_initial_set", 15);

    prev_d2 = 1;
    prev_d4 = 1;
    rise_d2 = 0;
    rise_d4 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      aset = vecs[i].aset;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), int'(out), vecs[i].exp_out);
      check($sformatf("vec%0d_div2", i), int'(div2), vecs[i].exp_d2);
      check($sformatf("vec%0d_div4", i), int'(div4), vecs[i].exp_d4);
      if (i >= 3 && i < 19) begin
        if (prev_d2 == 0 && div2 == 1'b1) rise_d2++;
        if (prev_d4 == 0 && div4 == 1'b1) rise_d4++;
      end
      prev_d2 = int'(div2);
      prev_d4 = int'(div4);
    end
    check("div2_rising_transitions", rise_d2, 8);
    check("div4_rising_transitions", rise_d4, 4);

    // Mid-count set: advance from 0 to 6, pulse aset between edges.
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("mid_step%0d", i), i);
    end
    @(negedge clk);
    aset = 1'b1;
    #1 check_all("mid_set_async", 15);
    #2 aset = 1'b0;
    #1 check_all("mid_set_held_after_release", 15);
    @(posedge clk);
    #1 check_all("mid_first_edge_after_release", 0);

    // Async set with the clock frozen low.
    @(negedge clk);
    #1 clk_en = 1'b0;
    #20 check_all("static_before_set", 0);
    aset = 1'b1;
    #1 check_all("static_async_set", 15);
    #20;
    check("static_clk_low", int'(clk), 0);
    check_all("static_set_held", 15);
    aset = 1'b0;
    #2 clk_en = 1'b1;
    @(posedge clk);
    #1 check_all("static_resume_first_edge", 0);
    model = 0;

    // Randomised set pulses against an arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aset = ($urandom_range(0, 7) == 0);
      if (aset) begin
        model = 15;
        #1 check_all($sformatf("rnd%0d_async", i), model);
      end
      @(posedge clk);
      #1;
      if (!aset) model = (model + 1) % 16;
      check_all($sformatf("rnd%0d", i), model);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
